// File: rtl/trigger_conditioner.sv
// Trigger conditioner: synchronizes and debounces a trigger level, qualifies edges,
// and gates accepted triggers through an arm / holdoff sequencer with counting.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_DISARMED | qualified edges ignored, waiting for arm
// S_ARMED    | next qualified edge is accepted as a trigger
// S_HOLDOFF  | dead time after a trigger; qualified edges flag missed
module trigger_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES  = 256,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [1:0]       edge_sel,
  input  logic             arm,
  input  logic             clr,
  output logic             level,
  output logic             trig_pulse,
  output logic             holdoff_active,
  output logic [CNT_W-1:0] trig_count,
  output logic             missed
);

  localparam logic [15:0]      DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]      HOLD_LAST = 16'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_HOLDOFF  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   din_s;
  logic [15:0]            deb_cnt;
  logic                   level_d;
  logic                   lvl_rise;
  logic                   lvl_fall;
  logic                   qual_edge;
  state_t                 state;
  logic [15:0]            hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign din_s = sync_q[SYNC_STAGES-1];

  // Level flips only after din_s has disagreed with it for DEBOUNCE_CYCLES straight cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level_d <= level;
      if (din_s == level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        level   <= ~level;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
    end
  end

  assign lvl_rise = level & ~level_d;
  assign lvl_fall = ~level & level_d;

  always_comb begin
    qual_edge = 1'b0;
    case (edge_sel)
      2'b00:   qual_edge = lvl_rise;
      2'b01:   qual_edge = lvl_fall;
      2'b10:   qual_edge = lvl_rise | lvl_fall;
      default: qual_edge = 1'b0;
    endcase
  end

  // clr is applied last so it overrides any increment or missed set in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_DISARMED;
      hold_cnt       <= '0;
      trig_pulse     <= 1'b0;
      holdoff_active <= 1'b0;
      trig_count     <= '0;
      missed         <= 1'b0;
    end else begin
      trig_pulse <= 1'b0;
      case (state)
        S_DISARMED: begin
          if (arm) begin
            state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (!arm) begin
            state <= S_DISARMED;
          end else if (qual_edge) begin
            trig_pulse     <= 1'b1;
            holdoff_active <= 1'b1;
            hold_cnt       <= HOLD_LAST;
            state          <= S_HOLDOFF;
            if (trig_count != CNT_MAX) begin
              trig_count <= trig_count + CNT_ONE;
            end
          end
        end
        S_HOLDOFF: begin
          if (qual_edge) begin
            missed <= 1'b1;
          end
          if (hold_cnt == 16'd0) begin
            holdoff_active <= 1'b0;
            state          <= arm ? S_ARMED : S_DISARMED;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        default: begin
          holdoff_active <= 1'b0;
          state          <= S_DISARMED;
        end
      endcase
      if (clr) begin
        trig_count <= '0;
        missed     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trigger_conditioner.sv
// Bench for trigger_conditioner: directed scenarios plus a randomized run checked
// against a timestamp-style behavioural model of the trigger rules.
module tb_trigger_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din = 1'b0;
  logic [1:0]    edge_sel = 2'b00;
  logic          arm = 1'b0;
  logic          clr = 1'b0;
  logic          level;
  logic          trig_pulse;
  logic          holdoff_active;
  logic [CW-1:0] trig_count;
  logic          missed;

  int n_checks = 0;
  int n_fail   = 0;

  trigger_conditioner #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLDOFF_CYCLES(HOLD), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .edge_sel(edge_sel), .arm(arm), .clr(clr),
    .level(level), .trig_pulse(trig_pulse), .holdoff_active(holdoff_active),
    .trig_count(trig_count), .missed(missed)
  );

  always #5 clk = ~clk;

  // Reference model: din delay line, mismatch run length, remaining holdoff time.
  bit m_q[$];
  bit m_level, m_was_rise, m_was_fall, m_armed, m_pulse, m_missed;
  int m_run, m_hold_left, m_count;

  task automatic model_reset();
    m_q = {};
    for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
    m_level = 0; m_was_rise = 0; m_was_fall = 0; m_armed = 0;
    m_pulse = 0; m_missed = 0; m_run = 0; m_hold_left = 0; m_count = 0;
  endtask

  task automatic model_step();
    bit ds, rise, fall, qual;
    if (rst) begin
      model_reset();
      return;
    end
    ds = m_q.pop_front();
    m_q.push_back(din);
    rise = m_was_rise;
    fall = m_was_fall;
    qual = (edge_sel == 2'b00 && rise) || (edge_sel == 2'b01 && fall) ||
           (edge_sel == 2'b10 && (rise || fall));
    m_was_rise = 0;
    m_was_fall = 0;
    if (ds != m_level) begin
      m_run++;
      if (m_run == DEB) begin
        m_level = !m_level;
        m_run = 0;
        if (m_level) m_was_rise = 1; else m_was_fall = 1;
      end
    end else begin
      m_run = 0;
    end
    m_pulse = 0;
    if (m_hold_left > 0) begin
      if (qual) m_missed = 1;
      m_hold_left--;
      if (m_hold_left == 0) m_armed = arm;
    end else if (m_armed) begin
      if (!arm) m_armed = 0;
      else if (qual) begin
        m_pulse = 1;
        m_hold_left = HOLD;
        if (m_count < (1 << CW) - 1) m_count++;
      end
    end else if (arm) begin
      m_armed = 1;
    end
    if (clr) begin
      m_count = 0;
      m_missed = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; din = 0; arm = 0; clr = 0; edge_sel = 2'b00;
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (level !== 1'b0) begin n_fail++; $display("FAIL reset_level: got %b want 0", level); end
    n_checks++; if (trig_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", trig_pulse); end
    n_checks++; if (holdoff_active !== 1'b0) begin n_fail++; $display("FAIL reset_holdoff: got %b want 0", holdoff_active); end
    n_checks++; if (trig_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", trig_count); end
    n_checks++; if (missed !== 1'b0) begin n_fail++; $display("FAIL reset_missed: got %b want 0", missed); end
  endtask

  task automatic test_step_latency();
    int lvl_at, pulse_at, pulses, hold_cycles;
    do_reset();
    arm = 1; edge_sel = 2'b00;
    step(); step(); step();
    din = 1;
    lvl_at = -1; pulse_at = -1; pulses = 0; hold_cycles = 0;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (level === 1'b1 && lvl_at < 0) lvl_at = c;
      if (trig_pulse === 1'b1) begin
        if (pulse_at < 0) pulse_at = c;
        pulses++;
      end
      if (holdoff_active === 1'b1) hold_cycles++;
    end
    n_checks++; if (lvl_at != SYNC + DEB) begin n_fail++; $display("FAIL step_level_latency: got %0d want %0d", lvl_at, SYNC + DEB); end
    n_checks++; if (pulse_at != SYNC + DEB + 1) begin n_fail++; $display("FAIL step_pulse_latency: got %0d want %0d", pulse_at, SYNC + DEB + 1); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL step_pulse_count: got %0d want 1", pulses); end
    n_checks++; if (trig_count !== 4'd1) begin n_fail++; $display("FAIL step_trig_count: got %0d want 1", trig_count); end
    n_checks++; if (hold_cycles != HOLD) begin n_fail++; $display("FAIL step_holdoff_len: got %0d want %0d", hold_cycles, HOLD); end
  endtask

  task automatic test_glitch();
    int lvl_seen, pulses;
    int lens[2] = '{3, 2};
    do_reset();
    arm = 1; edge_sel = 2'b10;
    step(); step();
    lvl_seen = 0; pulses = 0;
    for (int p = 0; p < 2; p++) begin
      din = 1;
      for (int c = 0; c < lens[p]; c++) begin
        step();
        if (level === 1'b1) lvl_seen++;
        if (trig_pulse === 1'b1) pulses++;
      end
      din = 0;
      for (int c = 0; c < 15; c++) begin
        step();
        if (level === 1'b1) lvl_seen++;
        if (trig_pulse === 1'b1) pulses++;
      end
    end
    n_checks++; if (lvl_seen != 0) begin n_fail++; $display("FAIL glitch_level: got %0d high cycles want 0", lvl_seen); end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d want 0", pulses); end
    n_checks++; if (trig_count !== 4'd0) begin n_fail++; $display("FAIL glitch_count: got %0d want 0", trig_count); end
  endtask

  task automatic test_both_edges();
    int pulses;
    int seg[4] = '{10, 10, 5, 30};
    do_reset();
    arm = 1; edge_sel = 2'b10;
    step(); step(); step();
    pulses = 0;
    for (int s = 0; s < 4; s++) begin
      din = (s % 2 == 0);
      for (int c = 0; c < seg[s]; c++) begin
        step();
        if (trig_pulse === 1'b1) pulses++;
      end
    end
    n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL both_pulses: got %0d want 3", pulses); end
    n_checks++; if (trig_count !== 4'd3) begin n_fail++; $display("FAIL both_count: got %0d want 3", trig_count); end
    n_checks++; if (missed !== 1'b1) begin n_fail++; $display("FAIL both_missed: got %b want 1", missed); end
  endtask

  task automatic test_saturation();
    int pulses;
    do_reset();
    arm = 1; edge_sel = 2'b10;
    step(); step(); step();
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      din = ~din;
      for (int c = 0; c < 14; c++) begin
        step();
        if (trig_pulse === 1'b1) pulses++;
      end
    end
    n_checks++; if (pulses != 16) begin n_fail++; $display("FAIL sat_pulses: got %0d want 16", pulses); end
    n_checks++; if (trig_count !== 4'd15) begin n_fail++; $display("FAIL sat_count: got %0d want 15", trig_count); end
    din = ~din;
    for (int c = 0; c < SYNC + DEB; c++) step();
    clr = 1;
    step();
    clr = 0;
    n_checks++; if (trig_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_clr_pulse: got %b want 1", trig_pulse); end
    n_checks++; if (trig_count !== 4'd0) begin n_fail++; $display("FAIL sat_clr_count: got %0d want 0", trig_count); end
  endtask

  task automatic test_reset_mid_holdoff();
    int pulses, early;
    do_reset();
    arm = 1; edge_sel = 2'b00;
    step(); step();
    din = 1;
    for (int c = 0; c < SYNC + DEB + 1; c++) step();
    step(); step();
    n_checks++; if (holdoff_active !== 1'b1) begin n_fail++; $display("FAIL rsth_in_holdoff: got %b want 1", holdoff_active); end
    rst = 1; din = 0;
    step();
    n_checks++; if ({level, trig_pulse, holdoff_active, trig_count, missed} !== 8'd0)
      begin n_fail++; $display("FAIL rsth_outputs: got %b want 00000000", {level, trig_pulse, holdoff_active, trig_count, missed}); end
    rst = 0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (trig_pulse === 1'b1 || level === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rsth_quiet: got %0d active cycles want 0", pulses); end
    din = 1;
    early = 0;
    for (int c = 0; c < SYNC + DEB; c++) begin
      step();
      if (trig_pulse === 1'b1) early++;
    end
    step();
    n_checks++; if (early != 0 || trig_pulse !== 1'b1) begin n_fail++; $display("FAIL rsth_new_edge: got early=%0d pulse=%b want early=0 pulse=1", early, trig_pulse); end
  endtask

  task automatic test_arm_control();
    int pulses, lvl_seen;
    do_reset();
    arm = 0; edge_sel = 2'b10;
    step(); step();
    pulses = 0; lvl_seen = 0;
    for (int k = 0; k < 6; k++) begin
      din = ~din;
      for (int c = 0; c < 10; c++) begin
        step();
        if (trig_pulse === 1'b1) pulses++;
        if (level === 1'b1) lvl_seen = 1;
      end
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL arm0_pulses: got %0d want 0", pulses); end
    n_checks++; if (missed !== 1'b0) begin n_fail++; $display("FAIL arm0_missed: got %b want 0", missed); end
    n_checks++; if (lvl_seen != 1) begin n_fail++; $display("FAIL arm0_level_tracks: got %0d want 1", lvl_seen); end
    for (int c = 0; c < 10; c++) step();
    arm = 1;
    step(); step();
    din = 1;
    for (int c = 0; c < SYNC + DEB + 1; c++) step();
    n_checks++; if (trig_pulse !== 1'b1) begin n_fail++; $display("FAIL arm1_pulse: got %b want 1", trig_pulse); end
    step(); step();
    arm = 0;
    for (int c = 0; c < 10; c++) step();
    din = 0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (trig_pulse === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 0 || missed !== 1'b0) begin n_fail++; $display("FAIL arm_drop_disarm: got pulses=%0d missed=%b want 0/0", pulses, missed); end
    n_checks++; if (trig_count !== 4'd1) begin n_fail++; $display("FAIL arm_drop_count: got %0d want 1", trig_count); end
  endtask

  task automatic test_rst_din_high();
    int lvl_at, pulse_at;
    rst = 1; din = 1; arm = 1; clr = 0; edge_sel = 2'b00;
    step(); step(); step();
    rst = 0;
    lvl_at = -1; pulse_at = -1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (level === 1'b1 && lvl_at < 0) lvl_at = c;
      if (trig_pulse === 1'b1 && pulse_at < 0) pulse_at = c;
    end
    n_checks++; if (lvl_at != SYNC + DEB) begin n_fail++; $display("FAIL rsthigh_level: got %0d want %0d", lvl_at, SYNC + DEB); end
    n_checks++; if (pulse_at != SYNC + DEB + 1) begin n_fail++; $display("FAIL rsthigh_pulse: got %0d want %0d", pulse_at, SYNC + DEB + 1); end
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    arm = 1; edge_sel = 2'b10;
    hold = 1;
    for (int c = 0; c < 3000; c++) begin
      hold--;
      if (hold <= 0) begin
        din = ~din;
        hold = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 39) == 0) arm = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) edge_sel = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 60) == 0);
      rst = ($urandom_range(0, 400) == 0);
      step();
      n_checks++; if (level !== m_level) begin n_fail++; $display("FAIL rnd_level @%0d: got %b want %b", c, level, m_level); end
      n_checks++; if (trig_pulse !== m_pulse) begin n_fail++; $display("FAIL rnd_pulse @%0d: got %b want %b", c, trig_pulse, m_pulse); end
      n_checks++; if (holdoff_active !== (m_hold_left > 0)) begin n_fail++; $display("FAIL rnd_holdoff @%0d: got %b want %b", c, holdoff_active, m_hold_left > 0); end
      n_checks++; if (trig_count !== 4'(m_count)) begin n_fail++; $display("FAIL rnd_count @%0d: got %0d want %0d", c, trig_count, m_count); end
      n_checks++; if (missed !== m_missed) begin n_fail++; $display("FAIL rnd_missed @%0d: got %b want %b", c, missed, m_missed); end
    end
    rst = 0; clr = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_step_latency();
    test_glitch();
    test_both_edges();
    test_saturation();
    test_reset_mid_holdoff();
    test_arm_control();
    test_rst_din_high();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_conditioner.md
TRIGGER_CONDITIONER -- requirements
Module: trigger_conditioner

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on din, legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a level change, legal range 1..65535.
REQ-003 Parameter HOLDOFF_CYCLES, default 256: dead time after an accepted trigger, legal range 1..65535.
REQ-004 Parameter CNT_W, default 16: width of trig_count.
REQ-005 Port clk, input, 1: sole clock; all state SHALL update on its rising edge only.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port din, input, 1: asynchronous glitch-filtered trigger level from the upstream filter stage.
REQ-008 Port edge_sel, input, 2: edge select; 00 = rise, 01 = fall, 10 = both, 11 = none.
REQ-009 Port arm, input, 1: level enable for trigger acceptance.
REQ-010 Port clr, input, 1: single-cycle clear of trig_count and missed.
REQ-011 Port level, output, 1: debounced din level.
REQ-012 Port trig_pulse, output, 1: one-cycle accepted-trigger strobe.
REQ-013 Port holdoff_active, output, 1: high while in HOLDOFF.
REQ-014 Port trig_count, output, CNT_W: number of accepted triggers.
REQ-015 Port missed, output, 1: sticky flag, set when a qualified edge is rejected during HOLDOFF.

Function
REQ-016 din SHALL pass through a SYNC_STAGES-flop synchronizer (din_s); no other logic SHALL sample din.
REQ-017 Debounce: counter resets when din_s == level; when din_s != level it SHALL count up, and level SHALL toggle on the cycle the count reaches DEBOUNCE_CYCLES, with the counter returning to 0.
REQ-018 A din step held stable SHALL reach level exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles after the first clk edge that samples it.
REQ-019 A din pulse shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL NOT change level.
REQ-020 A qualified edge is a level transition matching edge_sel; it SHALL be a one-cycle internal event, valid in the cycle after level changes.
REQ-021 FSM states: DISARMED, ARMED, HOLDOFF; encoding is free.
REQ-022 DISARMED: qualified edges are ignored and not counted as missed; arm = 1 -> ARMED on the next cycle.
REQ-023 ARMED with arm = 0 -> DISARMED; no pulse is produced.
REQ-024 ARMED with arm = 1 and a qualified edge: trig_pulse = 1 for exactly one cycle (registered, same cycle as the event), trig_count increments, and the FSM goes to HOLDOFF.
REQ-025 HOLDOFF SHALL last exactly HOLDOFF_CYCLES cycles, counted from the first cycle holdoff_active = 1.
REQ-026 At HOLDOFF expiry the FSM goes to ARMED if arm = 1, else to DISARMED; arm changes during HOLDOFF are otherwise ignored.
REQ-027 A qualified edge during HOLDOFF, including its final cycle, SHALL set missed and SHALL NOT pulse or count.
REQ-028 trig_count SHALL saturate at 2^CNT_W - 1 and never wrap.
REQ-029 clr = 1 zeroes trig_count and missed next cycle and has priority over a simultaneous increment or missed set; trig_pulse is unaffected.
REQ-030 Changing edge_sel SHALL take effect on the next cycle and SHALL NOT generate an event by itself.
REQ-031 edge_sel = 11 SHALL suppress all qualified edges; level still tracks din.

Reset
REQ-032 rst = 1 in any cycle forces, on the next edge: synchronizer flops = 0, level = 0, debounce counter = 0, FSM = DISARMED, trig_pulse = 0, holdoff_active = 0, trig_count = 0, missed = 0.
REQ-033 rst SHALL take priority over every other input, including mid-HOLDOFF and mid-debounce.
REQ-034 After rst is released, a din already high SHALL produce level = 1 per REQ-018 and be treated as a rising edge.

Verification (bench params: DEBOUNCE_CYCLES = 4, HOLDOFF_CYCLES = 8, SYNC_STAGES = 2, CNT_W = 4)
REQ-035 arm = 1, edge_sel = 00, din 0->1 held -> level = 1 six cycles later, trig_pulse one cycle after that, trig_count = 1, holdoff_active high for 8 cycles.
REQ-036 din high pulses of 3 cycles and 2 cycles -> level stays 0, no trig_pulse, trig_count = 0.
REQ-037 edge_sel = 10, din toggles every 10 cycles -> pulse on each rise and each fall when outside holdoff; a fall within 8 cycles of an accepted rise -> missed = 1, count not incremented.
REQ-038 16 accepted triggers -> trig_count = 15 and held there; clr in the cycle of a 17th trigger -> trig_count = 0, trig_pulse still asserted.
REQ-039 rst asserted at HOLDOFF cycle 3 -> next cycle all outputs = 0, FSM DISARMED; after release with arm = 1 and din low -> no pulse until a new debounced edge.
REQ-040 arm = 0 with din toggling -> no pulses, missed = 0; arm dropped during HOLDOFF -> DISARMED at expiry.
